// File: rtl/eq_cfg_ctrl_if.sv
// Register-write/read port from the I2C slave plus the coefficient-update
// valid/ready channel toward the equalizer datapath.
interface eq_cfg_ctrl_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_we;
    logic [7:0] rd_data;
    logic       coef_valid;
    logic [3:0] coef_band;
    logic [7:0] coef_gain;
    logic       coef_ready;

    modport master (
        output reg_addr, reg_data, reg_we, coef_ready,
        input  rd_data, coef_valid, coef_band, coef_gain
    );

    modport slave (
        input  reg_addr, reg_data, reg_we, coef_ready,
        output rd_data, coef_valid, coef_band, coef_gain
    );
endinterface

// File: rtl/eq_cfg_ctrl.sv
// Equalizer configuration controller: shadow gains/control written over I2C,
// applied atomically at a sample boundary via a band-by-band coefficient handshake.

module eq_cfg_band #(
    parameter int              GAIN_W     = 8,
    parameter logic [GAIN_W-1:0] UNITY_GAIN = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [GAIN_W-1:0] wr_gain,
    input  logic              snap_en,
    input  logic              apply_en,
    output logic [GAIN_W-1:0] shadow_gain,
    output logic [GAIN_W-1:0] snap_gain,
    output logic [GAIN_W-1:0] active_gain
);
    logic [GAIN_W-1:0] shadow_q, shadow_d;
    logic [GAIN_W-1:0] snap_q, snap_d;
    logic [GAIN_W-1:0] active_q, active_d;

    always_comb begin
        shadow_d = wr_en    ? wr_gain  : shadow_q;
        snap_d   = snap_en  ? shadow_q : snap_q;
        active_d = apply_en ? snap_q   : active_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= UNITY_GAIN;
            snap_q   <= UNITY_GAIN;
            active_q <= UNITY_GAIN;
        end else begin
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            active_q <= active_d;
        end
    end

    assign shadow_gain = shadow_q;
    assign snap_gain   = snap_q;
    assign active_gain = active_q;
endmodule

module eq_cfg_ctrl #(
    parameter int         NUM_BANDS  = 8,
    parameter int         GAIN_W     = 8,
    parameter logic [7:0] UNITY_GAIN = 8'h80,
    parameter logic [7:0] MAX_GAIN   = 8'hC0
) (
    input  logic                        clk,
    input  logic                        rst,
    eq_cfg_ctrl_if.slave                bus,
    input  logic                        sample_tick,
    output logic [NUM_BANDS*GAIN_W-1:0] gain_active,
    output logic                        mute,
    output logic                        bypass,
    output logic                        busy,
    output logic                        cfg_applied
);
    localparam logic [7:0] ADDR_CTRL = 8'h10;
    localparam logic [7:0] ADDR_STAT = 8'h11;
    localparam logic [3:0] LAST_BAND = 4'(NUM_BANDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, XFER, DONE} state_e;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic       mute_sh_q, mute_sh_d;
    logic       byp_sh_q, byp_sh_d;
    logic       snap_mute_q, snap_mute_d;
    logic       snap_byp_q, snap_byp_d;
    logic       mute_q, mute_d;
    logic       bypass_q, bypass_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic              ctrl_wr, commit_wr, accept, last_accept, snap_en;
    logic [GAIN_W-1:0] gain_wr_data;
    logic [GAIN_W-1:0] coef_gain_c;

    logic [NUM_BANDS-1:0][GAIN_W-1:0] shadow_all, snap_all, active_all;

    assign ctrl_wr      = bus.reg_we && (bus.reg_addr == ADDR_CTRL);
    assign commit_wr    = ctrl_wr && bus.reg_data[0];
    assign accept       = (state_q == XFER) && bus.coef_ready;
    assign last_accept  = accept && (idx_q == LAST_BAND);
    assign snap_en      = (state_q == WAIT_TICK) && sample_tick;
    assign gain_wr_data = (bus.reg_data > MAX_GAIN) ? MAX_GAIN : bus.reg_data;

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        eq_cfg_band #(
            .GAIN_W     (GAIN_W),
            .UNITY_GAIN (UNITY_GAIN)
        ) u_band (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (bus.reg_we && (bus.reg_addr == 8'(b))),
            .wr_gain     (gain_wr_data),
            .snap_en     (snap_en),
            .apply_en    (accept && (idx_q == 4'(b))),
            .shadow_gain (shadow_all[b]),
            .snap_gain   (snap_all[b]),
            .active_gain (active_all[b])
        );
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (commit_wr) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                // A commit here is absorbed: the snapshot has not been taken yet.
                if (sample_tick) begin
                    state_d = XFER;
                    idx_d   = '0;
                end
            end
            XFER: begin
                if (commit_wr) pending_d = 1'b1;
                if (accept) begin
                    idx_d = idx_q + 4'd1;
                    if (last_accept) state_d = DONE;
                end
            end
            DONE: begin
                // A commit landing in this very cycle still re-arms.
                if (pending_q || commit_wr) begin
                    state_d   = WAIT_TICK;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mute_sh_d   = ctrl_wr ? bus.reg_data[1] : mute_sh_q;
        byp_sh_d    = ctrl_wr ? bus.reg_data[2] : byp_sh_q;
        snap_mute_d = snap_en ? mute_sh_q : snap_mute_q;
        snap_byp_d  = snap_en ? byp_sh_q  : snap_byp_q;
        // Applied on the final accept so they flip together with cfg_applied.
        mute_d      = last_accept ? snap_mute_q : mute_q;
        bypass_d    = last_accept ? snap_byp_q  : bypass_q;

        coef_gain_c = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if ((state_q == XFER) && (idx_q == 4'(b))) coef_gain_c = snap_all[b];
        end

        rd_data_d = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (bus.reg_addr == 8'(b)) rd_data_d = shadow_all[b];
        end
        if (bus.reg_addr == ADDR_CTRL) rd_data_d = {5'b0, byp_sh_q, mute_sh_q, 1'b0};
        if (bus.reg_addr == ADDR_STAT) rd_data_d = {4'b0, bypass_q, mute_q, pending_q, busy};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            mute_sh_q   <= 1'b0;
            byp_sh_q    <= 1'b0;
            snap_mute_q <= 1'b0;
            snap_byp_q  <= 1'b0;
            mute_q      <= 1'b0;
            bypass_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            mute_sh_q   <= mute_sh_d;
            byp_sh_q    <= byp_sh_d;
            snap_mute_q <= snap_mute_d;
            snap_byp_q  <= snap_byp_d;
            mute_q      <= mute_d;
            bypass_q    <= bypass_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign cfg_applied    = (state_q == DONE);
    assign bus.coef_valid = (state_q == XFER);
    assign bus.coef_band  = (state_q == XFER) ? idx_q : 4'd0;
    assign bus.coef_gain  = coef_gain_c;
    assign bus.rd_data    = rd_data_q;
    assign gain_active    = active_all;
    assign mute           = mute_q;
    assign bypass         = bypass_q;
endmodule

// File: tb/tb_eq_cfg_ctrl.sv
// Scoreboard bench for eq_cfg_ctrl: stimulus pushes expected band updates and
// applied configs from a register-level model; a monitor pops and compares.
module tb_eq_cfg_ctrl;
    localparam int N = 8;

    logic           clk = 0;
    logic           rst = 1;
    logic           sample_tick = 0;
    logic [N*8-1:0] gain_active;
    logic           mute, bypass, busy, cfg_applied;

    eq_cfg_ctrl_if bus ();

    eq_cfg_ctrl #(.NUM_BANDS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .sample_tick (sample_tick),
        .gain_active (gain_active),
        .mute        (mute),
        .bypass      (bypass),
        .busy        (busy),
        .cfg_applied (cfg_applied)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] band; logic [7:0] gain; } coef_t;
    typedef struct { logic [N*8-1:0] gains; bit mute; bit byp; int lat; int tcyc; } appl_t;
    coef_t exp_q[$];
    appl_t appl_q[$];

    // Register-level reference model.
    logic [7:0]     m_shadow [N];
    bit             m_mute_sh, m_byp_sh, m_mute, m_byp;
    logic [N*8-1:0] m_act;
    bit             m_armed, m_inflight, m_pend;

    // Ready driver controls.
    bit rand_ready = 0;
    int stall_band = 15, stall_len = 0, stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat(input logic [7:0] d);
        return (d > 8'hC0) ? 8'hC0 : d;
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0, m_byp, m_mute, m_pend, (m_armed | m_inflight)};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < N; b++) m_shadow[b] = 8'h80;
        m_act = {N{8'h80}};
        m_mute_sh = 0; m_byp_sh = 0; m_mute = 0; m_byp = 0;
        m_armed = 0; m_inflight = 0; m_pend = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.coef_ready = 1'($urandom_range(0, 1));
        else if (bus.coef_valid && int'(bus.coef_band) == stall_band && stall_cnt < stall_len) begin
            bus.coef_ready = 0;
            stall_cnt++;
        end else bus.coef_ready = 1;
    end

    // Monitor
    logic  pv = 0, pr = 0;
    logic [3:0] pb;
    logic [7:0] pg;
    coef_t mon_e;
    appl_t mon_a;
    always @(negedge clk) begin
        if (rst) pv = 0;
        else begin
            if (pv && !pr) begin
                chk("hold_valid", bus.coef_valid, 1);
                chk("hold_band", bus.coef_band, pb);
                chk("hold_gain", bus.coef_gain, pg);
            end
            if (bus.coef_valid && bus.coef_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL coef_unexpected: got band %0d gain %h expected no update", bus.coef_band, bus.coef_gain);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("coef_band", bus.coef_band, mon_e.band);
                    chk("coef_gain", bus.coef_gain, mon_e.gain);
                end
            end
            if (cfg_applied) begin
                if (appl_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL applied_unexpected: got cfg_applied=1 expected 0");
                end else begin
                    mon_a = appl_q.pop_front();
                    chk("applied_gains", gain_active, mon_a.gains);
                    chk("applied_mute", mute, mon_a.mute);
                    chk("applied_bypass", bypass, mon_a.byp);
                    chk("valid_low_done", bus.coef_valid, 0);
                    chk("pending_bands_left", exp_q.size(), 0);
                    if (mon_a.lat >= 0) chk("applied_latency", cyc - mon_a.tcyc, mon_a.lat);
                    m_act = mon_a.gains; m_mute = mon_a.mute; m_byp = mon_a.byp;
                    m_inflight = 0;
                    if (m_pend) begin m_pend = 0; m_armed = 1; end
                end
            end
            pv = bus.coef_valid; pr = bus.coef_ready; pb = bus.coef_band; pg = bus.coef_gain;
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.reg_addr = a; bus.reg_data = d; bus.reg_we = 1;
        @(posedge clk); #1;
        bus.reg_we = 0;
        if (int'(a) < N) m_shadow[a[2:0]] = sat(d);
        else if (a == 8'h10) begin
            m_mute_sh = d[1]; m_byp_sh = d[2];
            if (d[0]) begin
                if (m_inflight) m_pend = 1;
                else m_armed = 1;
            end
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        bus.reg_addr = a;
        @(posedge clk); #1;
        chk(name, bus.rd_data, exp);
    endtask

    task automatic tick(input int lat);
        appl_t a;
        coef_t c;
        sample_tick = 1;
        if (m_armed) begin
            for (int b = 0; b < N; b++) begin
                c.band = 4'(b); c.gain = m_shadow[b];
                exp_q.push_back(c);
                a.gains[b*8 +: 8] = m_shadow[b];
            end
            a.mute = m_mute_sh; a.byp = m_byp_sh; a.lat = lat; a.tcyc = cyc;
            appl_q.push_back(a);
            m_armed = 0; m_inflight = 1;
        end
        @(posedge clk); #1;
        sample_tick = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (m_inflight && n < 300) begin @(posedge clk); #1; n++; end
        chk(name, m_inflight, 0);
    endtask

    task automatic set_ready(input bit r, input int band, input int len);
        rand_ready = r; stall_band = band; stall_len = len; stall_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] g;
        bit mu, by;
        int mode, len, bnd;
        bus.reg_addr = 0; bus.reg_data = 0; bus.reg_we = 0; bus.coef_ready = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;

        chk("rst_valid", bus.coef_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_applied", cfg_applied, 0);
        chk("rst_mute_bypass", {mute, bypass}, 2'b00);
        chk("rst_gain_active", gain_active, {N{8'h80}});
        chk("rst_rd_data", bus.rd_data, 0);
        for (int b = 0; b < N; b++) rd(8'(b), 8'h80, "rst_shadow");
        rd(8'h11, 8'h00, "rst_status");

        wr(8'h03, 8'hFF);
        rd(8'h03, 8'hC0, "sat_readback");
        chk("sat_active_b3", gain_active[31:24], 8'h80);
        wr(8'h11, 8'hFF);
        rd(8'h11, 8'h00, "status_ro");
        rd(8'h20, 8'h00, "unmapped_rd");
        tick(0);
        chk("idle_tick_ignored", bus.coef_valid, 0);

        // Straight transfer, ready held high.
        for (int b = 0; b < N; b++) wr(8'(b), 8'(8'h10 + b));
        set_ready(0, 15, 0);
        wr(8'h10, 8'h01);
        rd(8'h11, m_status(), "status_armed");
        tick(N + 1);
        wait_done("done_plain");
        chk("gains_plain", gain_active, 64'h1716151413121110);

        // Three-cycle stall on band 2.
        set_ready(0, 2, 3);
        wr(8'h10, 8'h01);
        tick(N + 4);
        wait_done("done_stall");

        // Re-commit during transfer -> pending, second transfer applies the new gain.
        set_ready(0, 0, 8);
        wr(8'h10, 8'h01);
        tick(N + 9);
        wr(8'h00, 8'h55);
        wr(8'h10, 8'h01);
        rd(8'h11, m_status(), "status_pending");
        wait_done("done_first");
        chk("old_band0", gain_active[7:0], 8'h10);
        rd(8'h11, m_status(), "status_rearmed");
        set_ready(0, 15, 0);
        tick(N + 1);
        wait_done("done_second");
        chk("new_band0", gain_active[7:0], 8'h55);

        // Randomized configurations and handshake patterns.
        for (int it = 0; it < 8; it++) begin
            for (int b = 0; b < N; b++) begin
                g = 8'($urandom_range(0, 255));
                wr(8'(b), g);
            end
            mu = 1'($urandom_range(0, 1));
            by = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            len = $urandom_range(1, 5);
            bnd = $urandom_range(0, N - 1);
            if (mode == 0) set_ready(0, 15, 0);
            else if (mode == 1) set_ready(0, bnd, len);
            else set_ready(1, 15, 0);
            wr(8'h10, {5'b0, by, mu, 1'b1});
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            tick(mode == 0 ? N + 1 : (mode == 1 ? N + 1 + len : -1));
            wait_done("done_rand");
            rd(8'h11, m_status(), "status_rand");
            bnd = $urandom_range(0, N - 1);
            rd(8'(bnd), m_shadow[bnd], "shadow_rand");
        end

        // Reset in the middle of a transfer.
        set_ready(0, 15, 0);
        wr(8'h10, 8'h03);
        tick(N + 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        exp_q.delete();
        appl_q.delete();
        chk("rst_mid_mute", mute, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_gains", gain_active, {N{8'h80}});
        chk("rst_mid_valid", bus.coef_valid, 0);
        rd(8'h11, 8'h00, "rst_mid_status");
        rd(8'h00, 8'h80, "rst_mid_shadow");
        tick(0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", bus.coef_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
